stream_demultiplexer_1to3: RTL and testbench
============================================

Name: stream_demultiplexer_1to3

Overview:
- Registered 1-to-3 demultiplexer with a valid/ready handshake on the input and on each output.
- It is the distribution-side counterpart of the 3-to-1 selector used in the datapath: one producer word is steered to one of three consumers.
- Selector encoding is identical to the datapath's 3-to-1 mux:
  - 01 selects channel 1.
  - 10 selects channel 2.
  - Any other value (00 or 11) selects channel 0.
- Each output has a one-entry holding register, so one stalled consumer never corrupts the other channels.

Parameters:
- NBits, 32, data word width.
- CNT_WIDTH, 8, width of the selector-alias counter.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Selector  input  2  destination channel, sampled with In_Data when In_Valid=1.
- In_Data  input  NBits  input word.
- In_Valid  input  1  producer has a word.
- In_Ready  output  1  demux accepts the word this cycle.
- Out_Data0/1/2  output  NBits each  channel data.
- Out_Valid0/1/2  output  1 each  channel holds a word.
- Out_Ready0/1/2  input  1 each  consumer takes the word.
- Alias_Count  output  CNT_WIDTH  number of accepted words with Selector=11.

Behaviour:
- Reset (reset=0, async assert, sync release): all Out_Valid=0, all Out_Data=0, Alias_Count=0. Any held or in-flight words are discarded. In_Ready is combinational and evaluates to 1 while in reset state.
- Target decode: tgt = 1 if Selector=01, tgt = 2 if Selector=10, otherwise tgt = 0.
- In_Ready = !Out_Valid[tgt] | Out_Ready[tgt].
  - Combinational from Selector, valid and ready only; no dependence on In_Valid.
- Accept when In_Valid & In_Ready at a rising edge:
  - Next cycle, Out_Data[tgt] = In_Data and Out_Valid[tgt] = 1.
  - Latency is 1 cycle.
- Drain: Out_Valid[i] & Out_Ready[i] with no simultaneous load of channel i clears Out_Valid[i] next cycle. Out_Data[i] holds its last value.
- Simultaneous drain and load on the same channel: the new word replaces the old one and Out_Valid stays 1. This gives full throughput of 1 word/cycle per channel.
- Non-target channels are unaffected by an accept; they drain independently.
- Stability: while Out_Valid[i]=1 and Out_Ready[i]=0, Out_Data[i] and Out_Valid[i] must not change.
- Full channel with a stalled consumer: In_Ready=0 for words targeting it. The producer must hold Selector/In_Data/In_Valid stable. Words for other channels are still accepted once Selector changes.
- Alias_Count increments by 1 on each accepted word with Selector=11. It saturates at all-ones; no wrap.
- In_Valid=0: no load and no counter change, regardless of Selector.
- Order is preserved per channel. No ordering guarantee across channels.

Decomposition:
- Shared package holds:
  - SEL_CH0=2'b00, SEL_CH1=2'b01, SEL_CH2=2'b10, SEL_ALIAS=2'b11.
  - NUM_CH=3.
  - These are shared with the datapath 3-to-1 selector so both ends decode identically.
- One natural sub-module, demux_channel_slot (one-entry valid/ready holding register with load/drain), instantiated three times.
- Top level contains decode, In_Ready generation and the alias counter.

Test Plan:
- Reset mid-operation: load 0xDEADBEEF to ch1 and leave it stalled, then pulse reset=0 asynchronously -> Out_Valid1 drops immediately, Out_Data1=0, Alias_Count=0.
- Routing: In_Data=0x11, then 0x22, then 0x33 with Selector=00, then 01, then 10, all readies 1 -> one cycle later each word appears on ch0/ch1/ch2 respectively, Out_Valid pulses 1 cycle each.
- Alias: four words with Selector=11 -> all appear on ch0 and Alias_Count=4. With CNT_WIDTH=2, six alias words -> Alias_Count saturates at 3.
- Backpressure: Out_Ready2=0, send 0xA5 to ch2, then present 0x5A to ch2 -> In_Ready=0 and Out_Data2 stays 0xA5. Switch Selector to 01 -> 0x5A is accepted on ch1.
- Full throughput: Out_Ready0=1 constant, stream 0x1..0x8 to ch0 back-to-back -> In_Ready stays 1 and Out_Data0 shows 0x1..0x8 on consecutive cycles.
- Simultaneous drain+load: ch1 holds 0x77 with Out_Ready1 raised in the same cycle as a new 0x88 accept -> next cycle Out_Valid1=1 and Out_Data1=0x88, no bubble.

Source files
------------

// File: rtl/stream_demultiplexer_1to3_pkg.sv
// Selector encoding and channel count shared with the datapath 3-to-1 selector,
// so both ends of the stream decode the selector identically.
package stream_demultiplexer_1to3_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_CH0   = 2'b00;
  localparam sel_t SEL_CH1   = 2'b01;
  localparam sel_t SEL_CH2   = 2'b10;
  localparam sel_t SEL_ALIAS = 2'b11;

  localparam int unsigned NUM_CH = 3;

  // 00 and the 11 alias both fall through to channel 0.
  function automatic logic [1:0] decode_target(input sel_t sel);
    case (sel)
      SEL_CH1: return 2'd1;
      SEL_CH2: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stream_demultiplexer_1to3_demux_channel_slot.sv
// One-entry valid/ready holding register for a single demux output channel.
module demux_channel_slot #(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NBits-1:0] load_data,
  input  logic             drain,
  output logic [NBits-1:0] data,
  output logic             valid
);

  // A load wins over a drain in the same cycle, so the slot stays full
  // and the channel keeps one word per cycle of throughput.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demultiplexer_1to3.sv
// Registered 1-to-3 stream demultiplexer with per-channel holding registers
// and a saturating count of words accepted through the selector alias (11).
module stream_demultiplexer_1to3
  import stream_demultiplexer_1to3_pkg::*;
#(
  parameter int NBits     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Selector,
  input  logic [NBits-1:0]     In_Data,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  output logic [NBits-1:0]     Out_Data0,
  output logic [NBits-1:0]     Out_Data1,
  output logic [NBits-1:0]     Out_Data2,
  output logic                 Out_Valid0,
  output logic                 Out_Valid1,
  output logic                 Out_Valid2,
  input  logic                 Out_Ready0,
  input  logic                 Out_Ready1,
  input  logic                 Out_Ready2,
  output logic [CNT_WIDTH-1:0] Alias_Count
);

  logic [1:0]        tgt;
  logic              accept;
  logic [NUM_CH-1:0] slot_valid;
  logic [NUM_CH-1:0] slot_ready;
  logic [NUM_CH-1:0] slot_load;
  logic [NBits-1:0]  slot_data [NUM_CH];

  assign tgt        = decode_target(Selector);
  assign slot_ready = {Out_Ready2, Out_Ready1, Out_Ready0};

  // Ready depends only on the targeted slot, never on In_Valid.
  always_comb begin
    In_Ready = !slot_valid[tgt] || slot_ready[tgt];
  end

  assign accept = In_Valid && In_Ready;

  always_comb begin
    slot_load = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      slot_load[i] = accept && (tgt == 2'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_channel_slot #(
      .NBits(NBits)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (slot_load[g]),
      .load_data (In_Data),
      .drain     (slot_ready[g]),
      .data      (slot_data[g]),
      .valid     (slot_valid[g])
    );
  end

  assign Out_Data0  = slot_data[0];
  assign Out_Data1  = slot_data[1];
  assign Out_Data2  = slot_data[2];
  assign Out_Valid0 = slot_valid[0];
  assign Out_Valid1 = slot_valid[1];
  assign Out_Valid2 = slot_valid[2];

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Alias_Count <= '0;
    end else if (accept && (Selector == SEL_ALIAS) && (Alias_Count != '1)) begin
      Alias_Count <= Alias_Count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_stream_demultiplexer_1to3.sv
// Randomized scoreboard bench for the 1-to-3 stream demultiplexer.
module tb_stream_demultiplexer_1to3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready, in_ready_b;
  logic [31:0] out_data0, out_data1, out_data2;
  logic [31:0] out_data0_b, out_data1_b, out_data2_b;
  logic        out_valid0, out_valid1, out_valid2;
  logic        out_valid0_b, out_valid1_b, out_valid2_b;
  logic        out_ready0, out_ready1, out_ready2;
  logic [7:0]  alias_count;
  logic [1:0]  alias_count_b;

  always #5 clk = ~clk;

  stream_demultiplexer_1to3 #(.NBits(32), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .Selector(sel), .In_Data(in_data),
    .In_Valid(in_valid), .In_Ready(in_ready),
    .Out_Data0(out_data0), .Out_Data1(out_data1), .Out_Data2(out_data2),
    .Out_Valid0(out_valid0), .Out_Valid1(out_valid1), .Out_Valid2(out_valid2),
    .Out_Ready0(out_ready0), .Out_Ready1(out_ready1), .Out_Ready2(out_ready2),
    .Alias_Count(alias_count)
  );

  // Narrow-counter instance to see saturation at 3 quickly.
  stream_demultiplexer_1to3 #(.NBits(32), .CNT_WIDTH(2)) dut_w2 (
    .clk(clk), .reset(reset), .Selector(sel), .In_Data(in_data),
    .In_Valid(in_valid), .In_Ready(in_ready_b),
    .Out_Data0(out_data0_b), .Out_Data1(out_data1_b), .Out_Data2(out_data2_b),
    .Out_Valid0(out_valid0_b), .Out_Valid1(out_valid1_b), .Out_Valid2(out_valid2_b),
    .Out_Ready0(out_ready0), .Out_Ready1(out_ready1), .Out_Ready2(out_ready2),
    .Alias_Count(alias_count_b)
  );

  logic [2:0]  ov, ordy;
  logic [31:0] od [3];
  assign ov    = {out_valid2, out_valid1, out_valid0};
  assign ordy  = {out_ready2, out_ready1, out_ready0};
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;

  int total = 0;
  int bad   = 0;

  // Reference model: per-channel expected-word queues, occupancy, alias tally.
  logic [31:0] expq [3][$];
  bit          occ [3];
  int          alias_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int target_of(input logic [1:0] s);
    return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 0;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      occ[c] = 1'b0;
      expq[c].delete();
    end
    alias_cnt = 0;
  endtask

  // One cycle: drive after the rising edge, check and advance the model at the falling edge.
  task automatic step(input logic [1:0] s, input logic [31:0] d, input logic v,
                      input logic [2:0] r, output bit acc);
    int  t;
    bit  mrdy;
    @(posedge clk);
    #1;
    sel      = s;
    in_data  = d;
    in_valid = v;
    {out_ready2, out_ready1, out_ready0} = r;
    @(negedge clk);
    t    = target_of(s);
    mrdy = !occ[t] || r[t];
    chk("in_ready", 64'(in_ready), 64'(mrdy));
    chk("in_ready_w2", 64'(in_ready_b), 64'(mrdy));
    for (int c = 0; c < 3; c++)
      chk($sformatf("out_valid%0d", c), 64'(ov[c]), 64'(occ[c]));
    chk("alias_count", 64'(alias_count), 64'(sat(alias_cnt, 255)));
    chk("alias_count_w2", 64'(alias_count_b), 64'(sat(alias_cnt, 3)));
    acc = v && mrdy;
    for (int c = 0; c < 3; c++) begin
      if (acc && t == c) begin
        occ[c] = 1'b1;
        expq[c].push_back(d);
      end else if (occ[c] && r[c]) begin
        occ[c] = 1'b0;
      end
    end
    if (acc && s == 2'b11) alias_cnt++;
  endtask

  // Monitor: every output handshake must deliver the oldest expected word of that channel.
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (reset && ov[c] && ordy[c]) begin
          if (expq[c].size() == 0) begin
            chk($sformatf("unexpected_word_ch%0d", c), 64'(od[c]), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            chk($sformatf("out_data%0d", c), 64'(od[c]), 64'(expq[c].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    bit          acc;
    logic [1:0]  cs;
    logic [31:0] cd;
    logic        cv;
    logic [2:0]  rr;

    reset = 1'b0;
    sel = 2'b00; in_data = '0; in_valid = 1'b0;
    out_ready0 = 1'b0; out_ready1 = 1'b0; out_ready2 = 1'b0;
    model_clear();
    #3;
    chk("reset_valids", 64'(ov), 64'(0));
    chk("reset_data0", 64'(out_data0), 64'(0));
    chk("reset_alias", 64'(alias_count), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Routing
    step(2'b00, 32'h11, 1'b1, 3'b111, acc);
    step(2'b01, 32'h22, 1'b1, 3'b111, acc);
    step(2'b10, 32'h33, 1'b1, 3'b111, acc);
    step(2'b00, 32'h0, 1'b0, 3'b111, acc);
    // Alias words land on channel 0
    for (int i = 0; i < 4; i++) step(2'b11, 32'h100 + 32'(i), 1'b1, 3'b111, acc);
    step(2'b11, 32'h0, 1'b0, 3'b111, acc);
    chk("alias_after_4", 64'(alias_count), 64'(4));
    // Backpressure on ch2, then redirect the held word to ch1
    step(2'b10, 32'hA5, 1'b1, 3'b011, acc);
    step(2'b10, 32'h5A, 1'b1, 3'b011, acc);
    step(2'b10, 32'h5A, 1'b1, 3'b011, acc);
    chk("ch2_held", 64'(out_data2), 64'(32'hA5));
    step(2'b01, 32'h5A, 1'b1, 3'b011, acc);
    step(2'b00, 32'h0, 1'b0, 3'b111, acc);
    // Back-to-back stream into ch0
    for (int i = 1; i <= 8; i++) step(2'b00, 32'(i), 1'b1, 3'b111, acc);
    // Simultaneous drain and load on ch1
    step(2'b01, 32'h77, 1'b1, 3'b101, acc);
    step(2'b01, 32'h88, 1'b1, 3'b111, acc);
    step(2'b00, 32'h0, 1'b0, 3'b101, acc);
    chk("ch1_replaced", 64'(out_data1), 64'(32'h88));
    step(2'b00, 32'h0, 1'b0, 3'b111, acc);

    // Randomized traffic; the producer holds a stalled word stable
    acc = 1'b1;
    cv  = 1'b0;
    cs  = 2'b00;
    cd  = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!(cv && !acc)) begin
        cs = 2'($urandom_range(0, 3));
        cd = $urandom;
        cv = ($urandom_range(0, 4) != 0);
      end
      for (int k = 0; k < 3; k++) rr[k] = ($urandom_range(0, 3) != 0);
      step(cs, cd, cv, rr, acc);
    end

    // Flush everything out
    for (int i = 0; i < 3; i++) step(2'b00, 32'h0, 1'b0, 3'b111, acc);
    for (int c = 0; c < 3; c++)
      chk($sformatf("drained_ch%0d", c), 64'(expq[c].size()), 64'(0));

    // Asynchronous reset while ch1 is stalled with a word
    step(2'b01, 32'hDEAD_BEEF, 1'b1, 3'b101, acc);
    step(2'b00, 32'h0, 1'b0, 3'b101, acc);
    chk("ch1_stalled_data", 64'(out_data1), 64'(32'hDEAD_BEEF));
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_valid1", 64'(out_valid1), 64'(0));
    chk("async_reset_data1", 64'(out_data1), 64'(0));
    chk("async_reset_alias", 64'(alias_count), 64'(0));
    chk("async_reset_in_ready", 64'(in_ready), 64'(1));
    model_clear();
    @(negedge clk);
    #1;
    reset = 1'b1;
    step(2'b10, 32'hC0FFEE, 1'b1, 3'b111, acc);
    step(2'b00, 32'h0, 1'b0, 3'b111, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
